// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive-side framing controller for the serial link.
// Detects the start bit, times bit periods, strobes an external LSB-first
// shift register at mid-bit, checks the stop bit and hands the data byte to
// the consumer with ready/read handshake plus framing/overrun flags.
// Optional build macro: RX_START_GLITCH_REJECT_EN re-samples the line at the
// middle of the start bit and abandons the frame if it is high again.
module rx_frame_ctrl #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 serial_in,
   input  logic [DATA_BITS:0]   packet_data,
   output logic                 shift_strobe,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   input  logic                 data_read,
   output logic                 framing_error,
   output logic                 overrun_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(DATA_BITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2,
      LOAD  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic             serial_p1;
   logic             start_edge;
   logic             mid_bit;
   logic             glitch_abort;
   logic             fe_set;
   logic             fe_clr;
   logic             load_en;

   assign start_edge = serial_p1 & ~serial_in;
   assign mid_bit    = (clk_cnt == CNT_MID);

`ifdef RX_START_GLITCH_REJECT_EN
   // A line that is high again half way through the start bit was a glitch.
   assign glitch_abort = (state == RECV) && (bit_cnt == '0) && mid_bit && serial_in;
`else
   assign glitch_abort = 1'b0;
`endif

   // State register, bit timing counters and one-cycle line history
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         serial_p1 <= 1'b1;
      end else begin
         state     <= state_nxt;
         clk_cnt   <= clk_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         serial_p1 <= serial_in;
      end
   end

   // Next-state, counter advance, shift strobe and flag/load requests
   always_comb begin
      state_nxt    = state;
      clk_cnt_nxt  = clk_cnt;
      bit_cnt_nxt  = bit_cnt;
      shift_strobe = 1'b0;
      fe_set       = 1'b0;
      fe_clr       = 1'b0;
      load_en      = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_nxt   = RECV;
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               fe_clr      = 1'b1;
            end
         end
         RECV: begin
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_nxt = '0;
               bit_cnt_nxt = bit_cnt + BIT_ONE;
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_ONE;
            end
            // Bit 0 is the start bit; it is timed but never shifted in.
            if (mid_bit && (bit_cnt != '0)) begin
               shift_strobe = 1'b1;
               if (bit_cnt == BIT_STOP) begin
                  state_nxt = CHECK;
               end
            end
            if (glitch_abort) begin
               state_nxt   = IDLE;
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
            end
         end
         CHECK: begin
            if (packet_data[DATA_BITS]) begin
               state_nxt = LOAD;
            end else begin
               fe_set    = 1'b1;
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            load_en   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Consumer-side byte buffer, handshake and sticky error flags
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_data       <= '1;
         data_ready    <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         if (fe_clr) begin
            framing_error <= 1'b0;
         end else if (fe_set) begin
            framing_error <= 1'b1;
         end
         // A load takes priority over a simultaneous read acknowledge.
         if (load_en) begin
            rx_data    <= packet_data[DATA_BITS-1:0];
            data_ready <= 1'b1;
            if (data_ready && !data_read) begin
               overrun_error <= 1'b1;
            end
         end else if (data_read && data_ready) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Testbench for rx_frame_ctrl: attached LSB-first shift register, a
// frame-level timing model of the receiver and per-cycle output comparison.
module tb_rx_frame_ctrl;

   localparam int CPB     = 10;
   localparam int DB      = 8;
   localparam int FIRST_N = CPB + CPB / 2;      // first data strobe, cycles after start edge
   localparam int LAST_N  = FIRST_N + DB * CPB; // stop-bit strobe
   localparam int CHECK_N = LAST_N + 1;
   localparam int LOAD_N  = LAST_N + 2;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          serial_in = 1'b1;
   logic          data_read = 1'b0;
   logic [DB:0]   packet_data;
   logic          shift_strobe;
   logic [DB-1:0] rx_data;
   logic          data_ready;
   logic          framing_error;
   logic          overrun_error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobe_cyc[$];
   logic dr_last = 1'b0;
   int dr_rise = -1;
   bit rand_done = 1'b0;

   always #5 clk = ~clk;

   rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .packet_data(packet_data),
      .shift_strobe(shift_strobe), .rx_data(rx_data), .data_ready(data_ready),
      .data_read(data_read), .framing_error(framing_error), .overrun_error(overrun_error)
   );

   // External serial-to-parallel register: LSB-first, serial data enters at the MSB
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) packet_data <= '1;
      else if (shift_strobe) packet_data <= {serial_in, packet_data[DB:1]};
   end

   always @(posedge clk) begin
      if (n_rst && shift_strobe) strobe_cyc.push_back(cyc);
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (data_ready && !dr_last) dr_rise = cyc;
      dr_last = data_ready;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model (frame timeline arithmetic) ----------------
   bit          m_act = 1'b0;
   int          m_n = 0;
   logic        m_prev = 1'b1;
   logic [DB:0] m_bits = '0;
   int          m_nb = 0;
   logic [DB-1:0] m_rx = '1;
   bit          m_dr = 1'b0, m_fe = 1'b0, m_or = 1'b0;

   function automatic bit strobe_at(int n);
      return (n >= FIRST_N) && (n <= LAST_N) && (((n - FIRST_N) % CPB) == 0);
   endfunction

   always @(posedge clk) begin
      bit loading;
      if (!n_rst) begin
         m_act = 1'b0; m_n = 0; m_prev = 1'b1; m_rx = '1;
         m_dr = 1'b0; m_fe = 1'b0; m_or = 1'b0;
      end else begin
         loading = m_act && (m_n == LOAD_N);
         if (loading) begin
            if (m_dr && !data_read) m_or = 1'b1;
            m_rx = m_bits[DB-1:0];
            m_dr = 1'b1;
         end else if (data_read && m_dr) begin
            m_dr = 1'b0; m_or = 1'b0;
         end
         if (!m_act) begin
            if (m_prev && !serial_in) begin
               m_act = 1'b1; m_n = 1; m_nb = 0; m_fe = 1'b0;
            end
         end else begin
            if (strobe_at(m_n)) begin
               m_bits[m_nb] = serial_in;
               m_nb++;
            end
`ifdef RX_START_GLITCH_REJECT_EN
            if (m_n == CPB / 2 && serial_in) m_act = 1'b0;
`endif
            if (m_n == CHECK_N && !m_bits[DB]) begin
               m_fe = 1'b1; m_act = 1'b0;
            end
            if (m_n == LOAD_N) m_act = 1'b0;
            m_n++;
         end
         m_prev = serial_in;
      end
   end

   // Per-cycle comparison, away from the active edge
   always @(negedge clk) begin
      chk("shift_strobe", shift_strobe, m_act && strobe_at(m_n));
      chk("rx_data", rx_data, m_rx);
      chk("data_ready", data_ready, m_dr);
      chk("framing_error", framing_error, m_fe);
      chk("overrun_error", overrun_error, m_or);
   end

   // ---------------- stimulus ----------------
   task automatic tick1();
      @(negedge clk); #1;
   endtask

   task automatic hold(input logic b, input int k);
      serial_in = b;
      repeat (k) tick1();
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic stop, output int t0);
      t0 = cyc;
      hold(1'b0, CPB);
      for (int i = 0; i < DB; i++) hold(d[i], CPB);
      hold(stop, CPB);
      serial_in = 1'b1;
   endtask

   task automatic pulse_read();
      data_read = 1'b1;
      tick1();
      data_read = 1'b0;
   endtask

   initial begin
      int t0;
      int tmp;
      logic [DB-1:0] d;
      tick1(); tick1();
      chk("reset_rx_data", rx_data, 8'hFF);
      chk("reset_data_ready", data_ready, 1'b0);
      chk("reset_framing", framing_error, 1'b0);
      chk("reset_overrun", overrun_error, 1'b0);
      chk("reset_strobe", shift_strobe, 1'b0);
      n_rst = 1'b1;
      tick1(); tick1(); tick1();

      // Reset in the middle of a frame, after three strobes
      strobe_cyc.delete();
      hold(1'b0, CPB); hold(1'b1, CPB); hold(1'b1, CPB); hold(1'b0, CPB);
      chk("midreset_strobes_before", strobe_cyc.size(), 3);
      n_rst = 1'b0; serial_in = 1'b1;
      tick1(); tick1();
      chk("midreset_rx_data", rx_data, 8'hFF);
      chk("midreset_data_ready", data_ready, 1'b0);
      n_rst = 1'b1;
      repeat (30) tick1();
      chk("midreset_no_more_strobes", strobe_cyc.size(), 3);
      send_frame(8'h3C, 1'b1, t0);
      chk("after_reset_rx_data", rx_data, 8'h3C);
      chk("after_reset_ready", data_ready, 1'b1);
      pulse_read();
      hold(1'b1, 3);

      // Clean frame 0xA5: strobe timing and ready latency
      strobe_cyc.delete();
      send_frame(8'hA5, 1'b1, t0);
      hold(1'b1, 2);
      chk("a5_strobe_count", strobe_cyc.size(), 9);
      chk("a5_first_strobe", strobe_cyc[0] - t0, FIRST_N);
      tmp = 0;
      for (int i = 1; i < strobe_cyc.size(); i++)
         if (strobe_cyc[i] - strobe_cyc[i-1] != CPB) tmp++;
      chk("a5_strobe_spacing", tmp, 0);
      // Ready is set two edges after the final strobe's edge; visible the cycle after.
      chk("a5_ready_latency", dr_rise - strobe_cyc[8], 3);
      chk("a5_rx_data", rx_data, 8'hA5);
      chk("a5_framing", framing_error, 1'b0);
      pulse_read();

      // Bad stop bit on 0x5A
      send_frame(8'h5A, 1'b0, t0);
      hold(1'b1, 5);
      chk("5a_framing", framing_error, 1'b1);
      chk("5a_ready_unchanged", data_ready, 1'b0);
      chk("5a_rx_kept", rx_data, 8'hA5);
      d = 8'h81;
      hold(1'b0, 2);
      chk("fe_cleared_on_start", framing_error, 1'b0);
      hold(1'b0, CPB - 2);
      for (int i = 0; i < DB; i++) hold(d[i], CPB);
      hold(1'b1, CPB);
      chk("81_rx_data", rx_data, 8'h81);
      pulse_read();
      hold(1'b1, 3);

      // Back-to-back 0x11, 0x22 without reading
      send_frame(8'h11, 1'b1, t0);
      send_frame(8'h22, 1'b1, t0);
      hold(1'b1, 2);
      chk("ovr_rx_data", rx_data, 8'h22);
      chk("ovr_flag", overrun_error, 1'b1);
      pulse_read();
      chk("ovr_ready_cleared", data_ready, 1'b0);
      chk("ovr_flag_cleared", overrun_error, 1'b0);

      // Read coincident with the LOAD cycle of 0x77 while 0x66 is unread
      send_frame(8'h66, 1'b1, t0);
      fork
         send_frame(8'h77, 1'b1, t0);
         begin
            repeat (LOAD_N) tick1();
            data_read = 1'b1;
            tick1();
            data_read = 1'b0;
         end
      join
      hold(1'b1, 2);
      chk("loadwin_ready", data_ready, 1'b1);
      chk("loadwin_rx_data", rx_data, 8'h77);
      chk("loadwin_overrun", overrun_error, 1'b0);
      pulse_read();
      hold(1'b1, 3);

      // Three-cycle glitch on an idle line
      strobe_cyc.delete();
      hold(1'b0, 3);
      hold(1'b1, 120);
`ifdef RX_START_GLITCH_REJECT_EN
      chk("glitch_strobes", strobe_cyc.size(), 0);
      chk("glitch_ready", data_ready, 1'b0);
`else
      chk("glitch_strobes", strobe_cyc.size(), 9);
      chk("glitch_rx_data", rx_data, 8'hFF);
`endif
      pulse_read();

      // Randomised frames, noise and read pulses
      fork
         begin
            for (int it = 0; it < 40; it++) begin
               if ($urandom_range(0, 4) != 0) begin
                  d = 8'($urandom);
                  send_frame(d, ($urandom_range(0, 3) != 0), t0);
               end else begin
                  for (int s = 0; s < 4; s++) hold(1'($urandom), $urandom_range(1, 15));
               end
               hold(1'b1, $urandom_range(0, 12));
            end
            hold(1'b1, 120);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               repeat ($urandom_range(20, 200)) tick1();
               pulse_read();
            end
         end
      join

      repeat (5) tick1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side framing controller for the serial link.
- Detects the start bit and times each bit period with internal counters.
- Generates the shift-enable strobe for the external serial-to-parallel shift register, which is configured LSB-first with serial data entering at the MSB.
- Checks the stop bit in that register's parallel output, then buffers the data byte to the consumer under a ready/read handshake with framing and overrun error flags.

Parameters:
- CLKS_PER_BIT, 10: clk cycles per serial bit period; even, ≥4.
- DATA_BITS, 8: data bits per frame; the shift register width is DATA_BITS+1.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- serial_in  input  1  already-synchronized line; idle high.
- packet_data  input  DATA_BITS+1  shift register parallel output; [DATA_BITS]=stop bit, [DATA_BITS-1:0]=data.
- shift_strobe  output  1  one-cycle shift enable to the shift register.
- rx_data  output  DATA_BITS  buffered received byte.
- data_ready  output  1  rx_data holds an unread byte.
- data_read  input  1  consumer acknowledge, one-cycle pulse.
- framing_error  output  1  last frame had stop bit = 0.
- overrun_error  output  1  a byte was loaded while the previous one was unread.

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk.
  - All outputs 0 except rx_data = all ones.
  - FSM = IDLE; counters = 0; previous-line register = 1.
- Start detect: register serial_in each cycle as prev.
  - A start edge is prev=1 and serial_in=0, detected in IDLE only.
- FSM states:
  - IDLE:
    - On start edge, go to RECV, clear clk_cnt and bit_cnt, and clear framing_error.
  - RECV:
    - clk_cnt counts 0..CLKS_PER_BIT-1 and wraps; bit_cnt increments on each wrap.
    - bit_cnt=0 is the start bit; bit_cnt 1..DATA_BITS+1 are the data and stop bits.
    - shift_strobe=1 for exactly one cycle when clk_cnt==CLKS_PER_BIT/2-1 and bit_cnt ≥1.
    - After the strobe at bit_cnt=DATA_BITS+1, go to CHECK on the next cycle.
    - Total strobes per frame = DATA_BITS+1.
  - CHECK (one cycle; packet_data now holds the full frame):
    - packet_data[DATA_BITS]=1: go to LOAD.
    - Otherwise set framing_error=1 and go to IDLE; rx_data and data_ready are unchanged.
  - LOAD (one cycle):
    - rx_data<=packet_data[DATA_BITS-1:0]; data_ready<=1.
    - If data_ready was 1 and data_read=0 this cycle, overrun_error<=1 and the old byte is overwritten.
    - Go to IDLE.
- Handshake:
  - data_read=1 with data_ready=1 clears data_ready and overrun_error on the next edge.
  - data_read in the same cycle as LOAD: LOAD wins, data_ready stays 1 and no overrun is flagged.
  - data_read with data_ready=0 is ignored.
- The return to IDLE occurs mid stop bit with the line high. The next start edge is accepted as soon as the FSM is in IDLE, so back-to-back frames need no idle gap.
- serial_in is ignored outside IDLE, apart from the optional start check.
- framing_error stays set until the next start edge; overrun_error stays set until data_read.
- Latency: data_ready rises 2 cycles after the final strobe.
- Reset mid-frame: the FSM and counters return immediately to their reset values and no strobe is issued. The shift register reloads all ones on the same reset.

Optional Feature:
- Macro RX_START_GLITCH_REJECT_EN.
- When defined: in RECV at bit_cnt=0 and clk_cnt==CLKS_PER_BIT/2-1, serial_in is sampled.
  - If it is 1, the FSM aborts to IDLE with no strobes issued and no flag changes; framing_error remains cleared.
- When undefined: no mid-start check; any falling edge starts a full frame.

Test Plan (CLKS_PER_BIT=10, DATA_BITS=8, shift register model attached):
- Reset asserted mid-frame after 3 strobes -> all outputs 0, rx_data=0xFF, no further strobes; the next clean frame 0x3C is received correctly.
- Frame 0xA5 (start 0, bits LSB-first 1,0,1,0,0,1,0,1, stop 1) -> 9 strobes, each 10 cycles apart with the first 15 cycles after the edge; rx_data=0xA5; data_ready=1 two cycles after the last strobe; framing_error=0.
- Frame 0x5A with stop=0 -> framing_error=1, data_ready unchanged, rx_data keeps its prior value; the next valid frame start clears framing_error.
- Frame 0x11 then 0x22 back-to-back with no data_read -> rx_data=0x22, overrun_error=1; data_read pulse -> data_ready=0, overrun_error=0 next cycle.
- data_read pulsed in the LOAD cycle of frame 0x77 while the earlier 0x66 is unread -> data_ready stays 1, rx_data=0x77, overrun_error=0.
- 3-cycle low glitch on an idle line -> with RX_START_GLITCH_REJECT_EN: no strobes, return to IDLE; without it: 9 strobes and a frame is processed.
